// File: rtl/mask_frame_capture_pkg.sv
`default_nettype none
// ==========================================================================
// Package  : mask_frame_capture_pkg
// Purpose  : Mask geometry, RAM address width and capture state encoding
// Revision : 1.0
// ==========================================================================
package mask_frame_capture_pkg;

  // Mask geometry for a 1280x720 source decimated by 2**SCALE_LOG2
  localparam int WIDTH      = 320;
  localparam int HEIGHT     = 180;
  localparam int SCALE_LOG2 = 2;
  localparam int ADDR_W     = $clog2(2 * WIDTH * HEIGHT);

  typedef logic [1:0] cap_state_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_PUBLISH = 2'd2;

endpackage
`default_nettype wire

// File: rtl/mask_bank_ram.sv
`default_nettype none
// ==========================================================================
// Module   : mask_bank_ram
// Purpose  : Simple dual-port 1-bit RAM, bank bit on the address MSB, 2-cycle read
// Revision : 1.0
// ==========================================================================
module mask_bank_ram #(
  parameter int ADDR_W = 17
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              we_in,
  input  logic [ADDR_W-1:0] waddr_in,
  input  logic              wdata_in,
  input  logic              re_in,
  input  logic [ADDR_W-1:0] raddr_in,
  output logic              rdata_out
);
  import mask_frame_capture_pkg::*;

  // Each bank occupies a power-of-two half so the bank bit is a clean MSB
  localparam int DEPTH = 1 << ADDR_W;

  logic              mem [DEPTH];
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              re_q, re_d;
  logic              rdata_q, rdata_d;

  always_ff @(posedge clk_in) begin
    if (we_in) begin
      mem[waddr_in] <= wdata_in;
    end
  end

  always_comb begin
    raddr_d = raddr_in;
    re_d    = re_in;
    rdata_d = re_q & mem[raddr_q];
  end

  always_ff @(posedge clk_in) begin
    raddr_q <= raddr_d;
    if (rst_in) begin
      re_q    <= 1'b0;
      rdata_q <= 1'b0;
    end else begin
      re_q    <= re_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata_out = rdata_q;

endmodule
`default_nettype wire

// File: rtl/mask_frame_capture.sv
`default_nettype none
// ==========================================================================
// Module   : mask_frame_capture
// Purpose  : Decimate a thresholded pixel stream into a double-buffered mask
// Revision : 1.0
// ==========================================================================
module mask_frame_capture #(
  parameter int WIDTH      = mask_frame_capture_pkg::WIDTH,
  parameter int HEIGHT     = mask_frame_capture_pkg::HEIGHT,
  parameter int SCALE_LOG2 = mask_frame_capture_pkg::SCALE_LOG2
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [10:0]                   hcount_in,
  input  logic [9:0]                    vcount_in,
  input  logic                          mask_in,
  input  logic                          data_valid_in,
  input  logic                          consumer_busy_in,
  input  logic [10:0]                   rd_x_in,
  input  logic [9:0]                    rd_y_in,
  output logic                          rd_data_out,
  output logic                          frame_valid_out,
  output logic [$clog2(WIDTH*HEIGHT):0] pixel_count_out,
  output logic [7:0]                    dropped_out
);
  import mask_frame_capture_pkg::*;

  localparam int                OFF_W      = $clog2(WIDTH * HEIGHT);
  localparam int                AW         = OFF_W + 1;
  localparam int                CW         = OFF_W + 1;
  localparam logic [OFF_W-1:0]  LAST_OFF   = OFF_W'(WIDTH * HEIGHT - 1);
  localparam logic [31:0]       WIDTH_BITS = 32'(WIDTH);
  localparam logic [10:0]       WIDTH_X    = 11'(WIDTH);
  localparam logic [9:0]        HEIGHT_Y   = 10'(HEIGHT);
  localparam logic [10:0]       H_LOW      = 11'((1 << SCALE_LOG2) - 1);
  localparam logic [9:0]        V_LOW      = 10'((1 << SCALE_LOG2) - 1);

  // y*WIDTH + x as a sum of shifted rows; WIDTH is constant so only adders remain
  function automatic logic [OFF_W-1:0] lin_addr(input logic [10:0] x, input logic [9:0] y);
    logic [OFF_W-1:0] acc;
    acc = OFF_W'(x);
    for (int i = 0; i < 32; i++) begin
      if (WIDTH_BITS[i]) acc = acc + (OFF_W'(y) << i);
    end
    return acc;
  endfunction

  logic [10:0]      w_src_x;
  logic [9:0]       w_src_y;
  logic             w_sample, w_origin, w_last, w_we, w_rd_hit;
  logic [OFF_W-1:0] w_wr_off, w_rd_off;

  cap_state_t       state_q, state_d;
  logic             wr_bank_q, wr_bank_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    pix_cnt_q, pix_cnt_d;
  logic [7:0]       dropped_q, dropped_d;
  logic             frame_valid_q, frame_valid_d;

  assign w_src_x  = hcount_in >> SCALE_LOG2;
  assign w_src_y  = vcount_in >> SCALE_LOG2;
  assign w_sample = data_valid_in && ((hcount_in & H_LOW) == '0) && ((vcount_in & V_LOW) == '0)
                    && (w_src_x < WIDTH_X) && (w_src_y < HEIGHT_Y);
  assign w_origin = (hcount_in == '0) && (vcount_in == '0);
  assign w_wr_off = lin_addr(w_src_x, w_src_y);
  assign w_last   = (w_wr_off == LAST_OFF);
  assign w_rd_hit = (rd_x_in < WIDTH_X) && (rd_y_in < HEIGHT_Y);
  assign w_rd_off = lin_addr(rd_x_in, rd_y_in);

  always_comb begin
    state_d       = state_q;
    wr_bank_d     = wr_bank_q;
    count_d       = count_q;
    pix_cnt_d     = pix_cnt_q;
    dropped_d     = dropped_q;
    frame_valid_d = 1'b0;
    w_we          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_sample && w_origin) begin
          w_we    = 1'b1;
          count_d = CW'(mask_in);
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (w_sample) begin
          w_we = 1'b1;
          if (w_origin) begin
            count_d = CW'(mask_in);
          end else begin
            count_d = count_q + CW'(mask_in);
            if (w_last) state_d = ST_PUBLISH;
          end
        end
      end
      ST_PUBLISH: begin
        state_d = ST_IDLE;
        if (!consumer_busy_in) begin
          wr_bank_d     = ~wr_bank_q;
          frame_valid_d = 1'b1;
          pix_cnt_d     = count_q;
        end else if (dropped_q != 8'hFF) begin
          dropped_d = dropped_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= ST_IDLE;
      wr_bank_q     <= 1'b0;
      count_q       <= '0;
      pix_cnt_q     <= '0;
      dropped_q     <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_bank_q     <= wr_bank_d;
      count_q       <= count_d;
      pix_cnt_q     <= pix_cnt_d;
      dropped_q     <= dropped_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  // Reads always use the bank opposite the one being written this cycle
  mask_bank_ram #(
    .ADDR_W(AW)
  ) u_ram (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .we_in    (w_we),
    .waddr_in ({wr_bank_q, w_wr_off}),
    .wdata_in (mask_in),
    .re_in    (w_rd_hit),
    .raddr_in ({~wr_bank_q, w_rd_off}),
    .rdata_out(rd_data_out)
  );

  assign frame_valid_out = frame_valid_q;
  assign pixel_count_out = pix_cnt_q;
  assign dropped_out     = dropped_q;

endmodule
`default_nettype wire

// File: doc/mask_frame_capture.md
MASK_FRAME_CAPTURE -- requirements
Module: mask_frame_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 320, the mask width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 180, the mask height in pixels.
REQ-003 SHALL have parameter SCALE_LOG2, default 2, the source-to-mask decimation exponent; source frame is 1280x720.
REQ-004 SHALL have these ports:
  clk_in  input  1  single system clock; all logic on its rising edge; reset is synchronous and active-high.
  rst_in  input  1  synchronous active-high reset.
  hcount_in  input  11  source pixel column.
  vcount_in  input  10  source pixel row.
  mask_in  input  1  thresholded pixel value.
  data_valid_in  input  1  qualifies hcount_in, vcount_in and mask_in.
  consumer_busy_in  input  1  high while the downstream connected-components stage is reading the read bank.
  rd_x_in  input  11  read column in mask coordinates.
  rd_y_in  input  10  read row in mask coordinates.
  rd_data_out  output  1  mask bit at (rd_x_in, rd_y_in).
  frame_valid_out  output  1  one-cycle pulse; a new complete mask is in the read bank.
  pixel_count_out  output  $clog2(WIDTH*HEIGHT)+1  count of set pixels in the published mask.
  dropped_out  output  8  saturating count of completed frames discarded because the consumer was busy.

Function
REQ-005 SHALL sample a source pixel only when data_valid_in=1 and the low SCALE_LOG2 bits of both hcount_in and vcount_in are 0.
REQ-006 SHALL write each sample to address (vcount_in>>SCALE_LOG2)*WIDTH + (hcount_in>>SCALE_LOG2) in the write bank.
REQ-007 SHALL use two banks of WIDTH*HEIGHT bits each: one write bank and one read bank.
REQ-008 SHALL implement states IDLE, CAPTURE and PUBLISH.
REQ-009 IDLE SHALL move to CAPTURE on a sample at (0,0); that sample is written and the running set-pixel count is loaded with mask_in.
REQ-010 CAPTURE SHALL write every sample and add mask_in to the running count.
REQ-011 CAPTURE SHALL move to PUBLISH after writing address WIDTH*HEIGHT-1.
REQ-012 A sample at (0,0) seen in CAPTURE SHALL restart capture in the same bank with count = mask_in; the partial frame is never published.
REQ-013 PUBLISH SHALL last exactly one cycle and then return to IDLE.
REQ-014 In PUBLISH with consumer_busy_in=0, the same edge SHALL swap banks, set frame_valid_out=1 for one cycle, and load pixel_count_out with the running count.
REQ-015 In PUBLISH with consumer_busy_in=1, there SHALL be no swap and no pulse, dropped_out SHALL increment saturating at 255, and the read bank and pixel_count_out SHALL be unchanged.
REQ-016 Samples arriving in PUBLISH or IDLE, other than (0,0), SHALL be ignored.
REQ-017 Read latency SHALL be exactly 2 cycles: rd_data_out reflects the coordinates presented two edges earlier.
REQ-018 A read SHALL use the read bank that is current in the cycle its address is presented.
REQ-019 A read with rd_x_in>=WIDTH or rd_y_in>=HEIGHT SHALL return 0, with the same 2-cycle latency.
REQ-020 Reads and writes SHALL never target the same bank.
REQ-021 Write throughput SHALL be one sample per cycle, with no back-pressure on the source.

Reset
REQ-022 While rst_in=1, state SHALL be IDLE, write bank 0 and read bank 1.
REQ-023 While rst_in=1, frame_valid_out, pixel_count_out, dropped_out, rd_data_out and the running count SHALL be 0.
REQ-024 Reset mid-CAPTURE SHALL abandon the partial frame; the next publish requires a full frame starting at (0,0).
REQ-025 Reset SHALL NOT be required to clear RAM contents; the read bank is undefined until the first frame_valid_out.

Structure
REQ-026 WIDTH, HEIGHT, SCALE_LOG2, the address width $clog2(2*WIDTH*HEIGHT) and the state enum SHALL be placed in a shared package, also used by connected_components.
REQ-027 Storage SHALL be one sub-module, mask_bank_ram: a simple dual-port 1-bit BRAM of depth 2*WIDTH*HEIGHT with the bank bit as address MSB and a 2-cycle registered read.
REQ-028 The address multiply SHALL be a constant-width shift-add; no DSP inference is required.

Verification
REQ-029 Full frame with mask_in=1 only where hcount_in=400 and vcount_in=200, consumer idle -> frame_valid_out pulses once after the sample at (1276,716); pixel_count_out=1; read (100,50) -> 1 two cycles later; read (101,50) -> 0.
REQ-030 Two all-ones frames with consumer_busy_in=1 throughout the second frame's PUBLISH -> one pulse with pixel_count_out=57600; dropped_out=1; read bank still holds frame 1.
REQ-031 Frame restarted at (0,0) when vcount_in=300 -> no pulse; the next full frame publishes its own count only.
REQ-032 rst_in asserted for 1 cycle at vcount_in=500 -> all outputs 0; the following full frame publishes normally.
REQ-033 Read at (320,0) and at (0,180) -> rd_data_out=0; back-to-back reads every cycle across a publish edge -> data from the old bank before the pulse and from the new bank for addresses presented after it.
REQ-034 300 consecutive dropped frames -> dropped_out saturates at 255.
